instr_loader: RTL
=================

# instr_loader

Boot loader that receives a program as a byte stream and writes it word-by-word into instruction memory, holding the processor core in reset until the image is complete and verified. It is the writer side of the instruction memory that the core's fetch path reads. It sits between a host byte source (UART receiver, debug port) and the instruction memory write port, and drives the core's reset.

## Interface
- `ADDR_WIDTH`, 32: width of the memory byte address.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, 256: largest accepted image size, in words.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: pulse that aborts any load in progress and restarts at the header.
- `in_valid` input 1: byte source has a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte. A byte transfers when `in_valid && in_ready`.
- `mem_write_en` output 1: one-cycle instruction-memory write strobe.
- `mem_write_addr` output ADDR_WIDTH: write byte address, word aligned.
- `mem_write_data` output 32: write word.
- `cpu_rst` output 1: reset to the core. High while loading or in error.
- `done` output 1: image loaded and accepted.
- `error` output 1: image rejected.
- `words_loaded` output $clog2(MAX_WORDS+1): count of words written.

## Operation
- Stream format, all fields 32-bit big-endian (first byte goes to [31:24]):
  - header N (word count);
  - N instruction words;
  - checksum word (see Configuration).
- Byte assembly:
  - A 2-bit byte counter selects the byte lane.
  - A word completes on the handshake that carries byte 3.
  - The counter wraps to 0 after byte 3.
- States: S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR. Reset state is S_HDR.
- S_HDR:
  - Header complete with N == 0 or N > MAX_WORDS: go to S_ERR.
  - Otherwise latch N, clear the running sum and `words_loaded`, go to S_DATA.
- S_DATA, each completed word:
  - register one write pulse with address BASE_ADDR + 4·words_loaded;
  - add the word to the 32-bit running sum, modulo 2^32;
  - increment `words_loaded`.
  - After word N, go to S_CSUM.
- S_CSUM: checksum word complete. If it equals the running sum, go to S_DONE; otherwise go to S_ERR.
- S_DONE: `done`=1, `cpu_rst`=0.
- S_ERR: `error`=1, `cpu_rst`=1.
- In S_DONE and S_ERR, `in_ready`=0 and the loader waits for `start`.
- `in_ready` = (state ∈ {S_HDR, S_DATA, S_CSUM}) && !start.
- `start` from any state:
  - next state S_HDR;
  - byte counter and `words_loaded` cleared;
  - `done`/`error` cleared;
  - `cpu_rst`=1 from the next cycle.
  - If `start` and `in_valid` are high in the same cycle, the byte is not accepted.
- `rst` mid-load: all state cleared immediately, no write pulse issued. Memory contents are not touched.

## Timing
- Reset values:
  - `mem_write_en`=0, `mem_write_addr`=BASE_ADDR, `mem_write_data`=0;
  - `cpu_rst`=1, `done`=0, `error`=0, `words_loaded`=0;
  - `in_ready`=1 when `start`=0.
- Write latency: `mem_write_en` is high for exactly the one cycle after the byte-3 handshake. Address and data are valid in that same cycle. `words_loaded` updates on the same edge.
- `done` rises, and `cpu_rst` falls, on the same edge. That edge is:
  - with checksum: the edge after the checksum byte-3 handshake;
  - without checksum: the edge after the final write-pulse cycle. The last word is always written before the core leaves reset.
- `error` rises on the edge after the offending header or checksum completes.
- Full throughput: one byte per cycle. No bubbles are inserted, including across word boundaries and state transitions.

## Configuration
- `INSTR_LOADER_CSUM_EN` defined: S_CSUM is present and the checksum word is required and verified as above.
- `INSTR_LOADER_CSUM_EN` not defined:
  - no checksum word and no running-sum logic;
  - S_DATA goes directly to S_DONE after word N;
  - S_ERR is reachable only through a bad header.

## Test plan
- Good image, checksum enabled. Stream N=2, 0x2008_0005, 0x2009_0003, checksum 0x4011_0008, one byte per cycle.
  - Exactly two write pulses: (0x0, 0x2008_0005) and (0x4, 0x2009_0003).
  - `done`=1 and `cpu_rst`=0 one cycle after the last checksum byte; `words_loaded`=2.
- Bad checksum. Same image with checksum 0x4011_0009.
  - `error`=1 and `cpu_rst` stays 1; `in_ready`=0.
  - `start` pulse then returns `in_ready` to 1 with `error`=0.
- Header bounds.
  - N=0 leads to `error`=1 with no write pulse.
  - N=257 with MAX_WORDS=256 leads to `error`=1.
  - N=256 is accepted, and the last write address is 0x3FC.
- Back-pressure. Deassert `in_valid` randomly between bytes.
  - Word assembly and byte order are unchanged.
  - Write pulses stay one cycle wide.
- Abort. Assert `start` after 6 data bytes, with `in_valid` high in the same cycle.
  - That byte is not accepted, and the byte counter and `words_loaded` are cleared.
  - A fresh full image then loads correctly, starting at BASE_ADDR.
- Async reset mid-word. Assert `rst` between bytes 1 and 2 of a data word.
  - All outputs take their reset values immediately, with no write pulse.
- Build without `INSTR_LOADER_CSUM_EN`. Load the N=2 image without the checksum word.
  - `done` rises one cycle after the second write pulse.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: boot loader that assembles a big-endian byte stream into 32-bit words and writes
// them into instruction memory, holding the core in reset until the image is complete.
//
// Stream: header N (word count), N instruction words, then a checksum word when the optional
// checksum is built in. Every field is 32-bit big-endian: the first byte lands in [31:24].
//
// Optional feature macro: INSTR_LOADER_CSUM_EN
//   defined   - the checksum word is required and must equal the 32-bit sum of the image words.
//   undefined - no checksum word, and the error state is reachable only through a bad header.
//
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   start           - abort any load and restart at the header
//   in_valid/in_data/in_ready - byte stream handshake
//   mem_write_en/addr/data    - one-cycle instruction-memory write port
//   cpu_rst         - core reset, high until the image is accepted
//   done, error     - image accepted / image rejected
//   words_loaded    - number of words written so far
module instr_loader #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            MAX_WORDS  = 256,
  localparam int unsigned           CW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [CW-1:0]         words_loaded
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
`ifdef INSTR_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd2;
`endif
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [CW-1:0]         n_words_q, n_words_d;
  logic [CW-1:0]         wl_q, wl_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
`ifdef INSTR_LOADER_CSUM_EN
  logic [31:0]           sum_q, sum_d;
`else
  // Set while the final write pulse is out; done follows one cycle later so the last
  // word is in memory before the core leaves reset.
  logic                  fin_q, fin_d;
`endif

  logic        loading;
  logic        hs;
  logic        word_done;
  logic [31:0] word;

  assign loading = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef INSTR_LOADER_CSUM_EN
                   || (state_q == S_CSUM);
`else
                   ;
`endif

`ifdef INSTR_LOADER_CSUM_EN
  assign in_ready = loading && !start;
`else
  assign in_ready = loading && !start && !fin_q;
`endif

  assign hs        = in_valid && in_ready;
  assign word_done = hs && (byte_cnt_q == 2'd3);
  // The completing word is the three buffered bytes plus the byte on the bus this cycle.
  assign word      = {shift_q, in_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    n_words_d  = n_words_q;
    wl_d       = wl_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef INSTR_LOADER_CSUM_EN
    sum_d      = sum_q;
`else
    fin_d      = fin_q;
`endif

    if (start) begin
      state_d    = S_HDR;
      byte_cnt_d = 2'd0;
      wl_d       = '0;
`ifndef INSTR_LOADER_CSUM_EN
      fin_d      = 1'b0;
`endif
    end else begin
      if (hs) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        shift_d    = {shift_q[15:0], in_data};
      end

      case (state_q)
        S_HDR: begin
          if (word_done) begin
            if ((word == 32'd0) || (word > MAX_WORDS)) begin
              state_d = S_ERR;
            end else begin
              n_words_d = CW'(word);
              wl_d      = '0;
`ifdef INSTR_LOADER_CSUM_EN
              sum_d     = 32'd0;
`endif
              state_d   = S_DATA;
            end
          end
        end

        S_DATA: begin
`ifndef INSTR_LOADER_CSUM_EN
          if (fin_q) begin
            fin_d   = 1'b0;
            state_d = S_DONE;
          end else
`endif
          if (word_done) begin
            we_d    = 1'b1;
            waddr_d = BASE_ADDR + ADDR_WIDTH'({wl_q, 2'b00});
            wdata_d = word;
            wl_d    = wl_q + CW'(1);
`ifdef INSTR_LOADER_CSUM_EN
            sum_d   = sum_q + word;
            if (wl_q + CW'(1) == n_words_q) state_d = S_CSUM;
`else
            if (wl_q + CW'(1) == n_words_q) fin_d = 1'b1;
`endif
          end
        end

`ifdef INSTR_LOADER_CSUM_EN
        S_CSUM: begin
          if (word_done) state_d = (word == sum_q) ? S_DONE : S_ERR;
        end
`endif

        S_DONE, S_ERR: ;

        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      n_words_q  <= '0;
      wl_q       <= '0;
      we_q       <= 1'b0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= 32'd0;
`ifdef INSTR_LOADER_CSUM_EN
      sum_q      <= 32'd0;
`else
      fin_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      n_words_q  <= n_words_d;
      wl_q       <= wl_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef INSTR_LOADER_CSUM_EN
      sum_q      <= sum_d;
`else
      fin_q      <= fin_d;
`endif
    end
  end

  assign mem_write_en   = we_q;
  assign mem_write_addr = waddr_q;
  assign mem_write_data = wdata_q;
  assign words_loaded   = wl_q;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
  assign cpu_rst        = (state_q != S_DONE);

endmodule
